// File: rtl/cva6_rvfi_trace_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cva6_rvfi_trace_sequencer                                                  |
// | Serialises multi-port RVFI commit records into one ordered trace stream,   |
// | with order stamping and drop accounting. Optional RVFI_TRACE_TIMESTAMP_EN  |
// | adds a per-record cycle timestamp on trace_cycle_o.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cva6_rvfi_trace_sequencer #(
   parameter int unsigned NrCommitPorts = 2,
   parameter int unsigned PayloadW      = 256,
   parameter int unsigned Depth         = 8,
   parameter int unsigned OrderW        = 64
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NrCommitPorts-1:0]          commit_valid_i,
   input  logic [NrCommitPorts*PayloadW-1:0] commit_data_i,
   input  logic                              flush_i,
   input  logic                              clear_ovf_i,
   output logic                              trace_valid_o,
   input  logic                              trace_ready_i,
   output logic [PayloadW-1:0]               trace_data_o,
   output logic [OrderW-1:0]                 trace_order_o,
`ifdef RVFI_TRACE_TIMESTAMP_EN
   output logic [OrderW-1:0]                 trace_cycle_o,
`endif
   output logic [$clog2(Depth):0]            occupancy_o,
   output logic                              overflow_o,
   output logic [OrderW-1:0]                 drop_cnt_o
);

   localparam int unsigned c_PTR_W = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned c_OCC_W = $clog2(Depth) + 1;
   localparam int unsigned c_SUM_W = OrderW + 1;
`ifdef RVFI_TRACE_TIMESTAMP_EN
   localparam int unsigned c_ENTRY_W = PayloadW + 2 * OrderW;
`else
   localparam int unsigned c_ENTRY_W = PayloadW + OrderW;
`endif

   logic [c_ENTRY_W-1:0] r_mem [Depth];
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_OCC_W-1:0]   r_occ;
   logic [OrderW-1:0]    r_order;
   logic [OrderW-1:0]    r_drop_cnt;
   logic                 r_ovf;
`ifdef RVFI_TRACE_TIMESTAMP_EN
   logic [OrderW-1:0]    r_cycle;
`endif

   logic [c_OCC_W-1:0]   w_off   [NrCommitPorts];
   logic [c_PTR_W-1:0]   w_slot  [NrCommitPorts];
   logic [c_ENTRY_W-1:0] w_entry [NrCommitPorts];
   logic [c_OCC_W-1:0]   w_n;
   logic [c_OCC_W-1:0]   w_free;
   logic [c_OCC_W-1:0]   w_push_n;
   logic                 w_pop;
   logic                 w_store;
   logic                 w_drop;
   logic [OrderW-1:0]    w_drop_base;
   logic [c_SUM_W-1:0]   w_drop_sum;

   // Each valid port lands at its rank among the valid ports: compaction.
   always_comb begin
      w_n = '0;
      for (int i = 0; i < int'(NrCommitPorts); i++) begin
         w_off[i]  = w_n;
         w_slot[i] = r_wr_ptr + w_off[i][c_PTR_W-1:0];
`ifdef RVFI_TRACE_TIMESTAMP_EN
         w_entry[i] = {r_cycle, r_order + OrderW'(w_off[i]),
                       commit_data_i[i*PayloadW +: PayloadW]};
`else
         w_entry[i] = {r_order + OrderW'(w_off[i]),
                       commit_data_i[i*PayloadW +: PayloadW]};
`endif
         w_n = w_n + c_OCC_W'(commit_valid_i[i]);
      end
   end

   // Whole-group admission; flush discards the push without counting a drop.
   always_comb begin
      w_pop       = (r_occ != '0) && trace_ready_i;
      w_free      = c_OCC_W'(Depth) - r_occ + c_OCC_W'(w_pop);
      w_store     = !flush_i && (w_n != '0) && (w_n <= w_free);
      w_drop      = !flush_i && (w_n > w_free);
      w_push_n    = w_store ? w_n : '0;
      w_drop_base = clear_ovf_i ? '0 : r_drop_cnt;
      w_drop_sum  = {1'b0, w_drop_base} + c_SUM_W'(w_n);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int d = 0; d < int'(Depth); d++) begin
            r_mem[d] <= '0;
         end
      end else if (w_store) begin
         for (int i = 0; i < int'(NrCommitPorts); i++) begin
            if (commit_valid_i[i]) begin
               r_mem[w_slot[i]] <= w_entry[i];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_occ      <= '0;
         r_order    <= '0;
         r_drop_cnt <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_order <= r_order + OrderW'(w_n);
         if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
         end else begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
            r_wr_ptr <= r_wr_ptr + w_push_n[c_PTR_W-1:0];
            r_occ    <= r_occ + w_push_n - c_OCC_W'(w_pop);
         end
         // A same-cycle drop overrides the clear so no loss goes unreported.
         if (w_drop) begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= w_drop_sum[OrderW] ? '1 : w_drop_sum[OrderW-1:0];
         end else if (clear_ovf_i) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

`ifdef RVFI_TRACE_TIMESTAMP_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cycle <= '0;
      end else begin
         r_cycle <= r_cycle + 1'b1;
      end
   end

   assign trace_cycle_o = r_mem[r_rd_ptr][PayloadW+OrderW +: OrderW];
`endif

   assign trace_valid_o = (r_occ != '0);
   assign trace_data_o  = r_mem[r_rd_ptr][PayloadW-1:0];
   assign trace_order_o = r_mem[r_rd_ptr][PayloadW +: OrderW];
   assign occupancy_o   = r_occ;
   assign overflow_o    = r_ovf;
   assign drop_cnt_o    = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/cva6_rvfi_trace_sequencer.md
Name: cva6_rvfi_trace_sequencer

Overview:
- Serialises the per-cycle, multi-port RVFI commit records produced by the CVA6 tracer into one in-order stream for a single-port trace sink (trace encoder, DPI bridge or off-chip trace port).
- Buffers bursts in a FIFO and stamps each record with a monotonically increasing order number.
- Accounts for records lost to sink backpressure, so the consumer can detect gaps.
- Sits between the RVFI tracer outputs and the trace sink, in the same clock domain as the core.

Parameters:
- NrCommitPorts, 2, number of commit ports presented per cycle (1..4).
- PayloadW, 256, width of one packed commit record in bits.
- Depth, 8, FIFO entries; power of two, must be >= NrCommitPorts.
- OrderW, 64, width of the order counter and the drop counter.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- commit_valid_i  in  NrCommitPorts  per-port record valid; port i is program-older than port i+1.
- commit_data_i  in  NrCommitPorts*PayloadW  packed records, port 0 in the LSBs.
- flush_i  in  1  synchronous discard of all buffered records.
- clear_ovf_i  in  1  clears overflow_o and drop_cnt_o.
- trace_valid_o  out  1  head record available.
- trace_ready_i  in  1  sink accepts the head record.
- trace_data_o  out  PayloadW  head record payload.
- trace_order_o  out  OrderW  order number of the head record.
- occupancy_o  out  $clog2(Depth)+1  entries currently held.
- overflow_o  out  1  sticky flag: at least one record dropped.
- drop_cnt_o  out  OrderW  records dropped since reset or last clear, saturating.

Behaviour:
- Reset: FIFO empty, read and write pointers 0, order counter 0, trace_valid_o=0, trace_data_o=0, trace_order_o=0, occupancy_o=0, overflow_o=0, drop_cnt_o=0.
- Push count per cycle: n = popcount(commit_valid_i).
- Compaction: valid ports are written to consecutive FIFO slots in ascending port index. Invalid ports in between are skipped, so valid pattern 0b101 yields two adjacent entries, port 0 first.
- Order numbers: the k-th valid record in a cycle (k from 0) receives order_q+k. order_q advances by n every cycle, whether the records are stored or dropped.
- Pop: occurs when trace_valid_o && trace_ready_i. The head entry is removed at the clock edge.
- Free slots: free = Depth - occupancy + pop. A pop in the same cycle frees space for that cycle's push.
- All-or-nothing admission:
  - if n <= free, all n records are stored;
  - otherwise none of the cycle's records are stored, drop_cnt_o += n (saturating at all-ones), and overflow_o is set.
  - Partial groups are never stored.
- Latency: a record pushed in cycle t appears at the output in cycle t+1 at the earliest. There is no fall-through.
- Output stability: trace_data_o and trace_order_o come directly from the head entry. They must hold stable while trace_valid_o=1 and trace_ready_i=0.
- trace_valid_o = (occupancy != 0).
- Pointer wrap: pointers are $clog2(Depth) bits and wrap modulo Depth. A multi-entry push that straddles the wrap writes slots Depth-1 and then 0.
- flush_i:
  - empties the FIFO (occupancy 0, pointers reset to 0) at the edge;
  - has priority over the same-cycle push and pop, so the same-cycle push is discarded and not counted as dropped;
  - still advances order_q by n;
  - does not affect overflow_o or drop_cnt_o.
- clear_ovf_i: zeroes overflow_o and drop_cnt_o. If a drop occurs in the same cycle, the drop wins: overflow_o=1 and drop_cnt_o=n.
- Full with a simultaneous pop: at occupancy=Depth with pop=1 and n=1, the record is stored and occupancy stays at Depth.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Buffered records are lost without incrementing drop_cnt_o.

Optional Feature:
- Macro: RVFI_TRACE_TIMESTAMP_EN.
- When defined:
  - a free-running OrderW-bit cycle counter (reset 0, wraps) is added;
  - each record stores the counter value of its push cycle;
  - an extra output port trace_cycle_o (out, OrderW) presents the head record's timestamp, with the same stability rule as trace_data_o.
- When undefined: the counter, the FIFO timestamp field and the trace_cycle_o port do not exist. FIFO width is PayloadW+OrderW.

Test Plan:
- Reset, then hold trace_ready_i=1 and push valid=0b11 with data A,B for one cycle -> cycle t+1 outputs A with order 0, cycle t+2 outputs B with order 1, cycle t+3 trace_valid_o=0.
- Hold trace_ready_i=0 and push valid=0b10 four times (Depth=8) -> occupancy_o=4, orders 0..3, no overflow. Release ready -> records drain in push order.
- trace_ready_i=0, fill 7 entries, then push valid=0b11 -> group dropped, occupancy_o=7, drop_cnt_o=2, overflow_o=1. The next accepted record carries order 9.
- Occupancy 8, trace_ready_i=1, push valid=0b01 -> stored, occupancy_o stays 8, output order sequence unbroken.
- With 3 entries buffered, assert flush_i together with valid=0b11 -> occupancy_o=0 next cycle, drop_cnt_o unchanged, the next pushed record has order 5 (3 buffered + 2 flushed).
- Pre-set drop_cnt_o=5, assert clear_ovf_i with no drop -> overflow_o=0, drop_cnt_o=0. With RVFI_TRACE_TIMESTAMP_EN, a record pushed at cycle 20 shows trace_cycle_o=20.
